// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB-to-counter bridge.
// Holds the address map, FSM state and decode-class encodings, IRQ_STAT field
// positions and the address decode helper used by apb_counter_bridge.
package apb_bridge_pkg;

    // Address map (byte addresses, compared zero-extended to 32 bits)
    localparam logic [31:0] ADDR_CTRL     = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS   = 32'h0000_0004;
    localparam logic [31:0] ADDR_IRQ_STAT = 32'h0000_0200;
    localparam logic [31:0] ADDR_IRQ_EN   = 32'h0000_0204;

    // IRQ_STAT / IRQ_EN field positions
    localparam int unsigned IRQ_PEND_BIT  = 0;
    localparam int unsigned EVCNT_LSB     = 8;
    localparam int unsigned EVCNT_W       = 8;
    localparam int unsigned CLR_PEND_BIT  = 0;
    localparam int unsigned CLR_CNT_BIT   = 1;
    localparam int unsigned IRQ_EN_BIT    = 0;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ClsFwd,
        ClsLocal,
        ClsErr
    } cls_e;

    function automatic cls_e decode(input logic [31:0] a);
        if (a == ADDR_CTRL || a == ADDR_STATUS) begin
            return ClsFwd;
        end else if (a == ADDR_IRQ_STAT || a == ADDR_IRQ_EN) begin
            return ClsLocal;
        end
        return ClsErr;
    endfunction

endpackage

// File: rtl/ovf_irq_latch.sv
// Overflow event latch.
// Detects rising edges of overflow and records them as a sticky pending flag
// plus a saturating 8-bit event count. Software clears both via one-cycle
// clear pulses; a coincident event always takes priority over a clear.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   overflow      counter overflow level input
//   clr_pending   one-cycle request to clear pending
//   clr_cnt       one-cycle request to clear ev_cnt
//   pending       sticky event flag
//   ev_cnt        saturating event count
module ovf_irq_latch
    import apb_bridge_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               overflow,
    input  logic               clr_pending,
    input  logic               clr_cnt,
    output logic               pending,
    output logic [EVCNT_W-1:0] ev_cnt
);

    logic ovf_d;
    logic ovf_event;

    // A held-high level only produces one event
    assign ovf_event = overflow & ~ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_d   <= 1'b0;
            pending <= 1'b0;
            ev_cnt  <= '0;
        end else begin
            ovf_d <= overflow;

            if (ovf_event) begin
                pending <= 1'b1;
            end else if (clr_pending) begin
                pending <= 1'b0;
            end

            // Event wins over clear so no overflow is ever lost
            if (ovf_event) begin
                if (ev_cnt != '1) begin
                    ev_cnt <= ev_cnt + 1'b1;
                end
            end else if (clr_cnt) begin
                ev_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/apb_counter_bridge.sv
// APB3 slave bridging to the counter register strobe interface.
// Every transfer takes SETUP + two ACCESS cycles: IDLE latches the request,
// XFER issues the single-cycle downstream strobe (or local register access),
// DONE presents pready with prdata/pslverr. Addresses 0x000/0x004 are
// forwarded, 0x200/0x204 are local IRQ registers, anything else errors.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   psel, penable, pwrite,
//   paddr, pwdata                APB3 request
//   pready, prdata, pslverr      APB3 response (registered)
//   wr_en, rd_en, addr, wdata    downstream strobes (registered)
//   rdata                        downstream read data, same cycle as rd_en
//   overflow                     counter overflow level
//   irq                          pending & irq_en
module apb_counter_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              overflow,
    output logic              irq
);

    state_e             state;
    cls_e               cls_q;
    logic               pwrite_q;
    logic               irq_en;
    logic               pending;
    logic [EVCNT_W-1:0] ev_cnt;

    logic               sel_stat;
    logic               local_wr;
    logic               clr_pending;
    logic               clr_cnt;
    logic [DATA_W-1:0]  local_rd;
    cls_e               req_cls;

    assign req_cls  = decode(32'(paddr));
    assign sel_stat = (32'(addr) == ADDR_IRQ_STAT);
    assign local_wr = (state == StXfer) && (cls_q == ClsLocal) && pwrite_q;

    // Clears take effect on the XFER->DONE edge, together with any local write
    assign clr_pending = local_wr && sel_stat && wdata[CLR_PEND_BIT];
    assign clr_cnt     = local_wr && sel_stat && wdata[CLR_CNT_BIT];

    always_comb begin
        local_rd = '0;
        if (sel_stat) begin
            local_rd[IRQ_PEND_BIT]           = pending;
            local_rd[EVCNT_LSB +: EVCNT_W]   = ev_cnt;
        end else begin
            local_rd[IRQ_EN_BIT]             = irq_en;
        end
    end

    assign irq = pending & irq_en;

    ovf_irq_latch u_ovf_irq_latch (
        .clk         (clk),
        .rst         (rst),
        .overflow    (overflow),
        .clr_pending (clr_pending),
        .clr_cnt     (clr_cnt),
        .pending     (pending),
        .ev_cnt      (ev_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            cls_q    <= ClsErr;
            pwrite_q <= 1'b0;
            irq_en   <= 1'b0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (psel && !penable) begin
                        state    <= StXfer;
                        addr     <= paddr;
                        wdata    <= pwdata;
                        pwrite_q <= pwrite;
                        cls_q    <= req_cls;
                        // Strobe is registered so it is high for the whole XFER cycle
                        wr_en    <= (req_cls == ClsFwd) && pwrite;
                        rd_en    <= (req_cls == ClsFwd) && !pwrite;
                    end
                end
                StXfer: begin
                    state   <= StDone;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                    pready  <= 1'b1;
                    pslverr <= (cls_q == ClsErr);
                    prdata  <= '0;
                    if (!pwrite_q) begin
                        if (cls_q == ClsFwd) begin
                            prdata <= rdata;
                        end else if (cls_q == ClsLocal) begin
                            prdata <= local_rd;
                        end
                    end
                    if (local_wr && !sel_stat) begin
                        irq_en <= wdata[IRQ_EN_BIT];
                    end
                end
                StDone: begin
                    state   <= StIdle;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
